cool_heat_ctrl: RTL and testbench

Mode and speed controller for the cooling/heating PWM path. It samples an 8-bit temperature and selects COOL, HEAT or idle using hysteresis thresholds. It computes a saturated target speed and ramps the 8-bit `speed` word, which drives the PWM duty-cycle generator, toward that target. Every mode exit drains speed to zero before the actuator enable drops.

---
 rtl/cool_heat_ctrl.sv | 140 ++++++++++++++
 tb/tb_cool_heat_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cool_heat_ctrl.sv
// cool_heat_ctrl: hysteresis COOL/HEAT mode selection driving an 8-bit PWM speed word.
// Define SOFT_START_EN for the tick-paced ramp; otherwise speed follows the target every edge.
module cool_heat_ctrl #(
   parameter int unsigned HEAT_ON  = 15,
   parameter int unsigned HEAT_OFF = 20,
   parameter int unsigned COOL_OFF = 30,
   parameter int unsigned COOL_ON  = 35,
   parameter int unsigned GAIN     = 16,
   parameter int unsigned TICK_DIV = 16,
   parameter int unsigned STEP     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] temp,
   input  logic       temp_valid,
   output logic [7:0] speed,
   output logic       cool_en,
   output logic       heat_en,
   output logic       busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COOL  = 2'd1;
   localparam logic [1:0] S_HEAT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [7:0]  HEAT_ON_B  = 8'(HEAT_ON);
   localparam logic [7:0]  HEAT_OFF_B = 8'(HEAT_OFF);
   localparam logic [7:0]  COOL_OFF_B = 8'(COOL_OFF);
   localparam logic [7:0]  COOL_ON_B  = 8'(COOL_ON);
   localparam logic [15:0] GAIN_W     = 16'(GAIN);

   logic [1:0]  state, next_state;
   logic [7:0]  temp_q;
   logic [7:0]  diff, target, speed_next;
   logic [15:0] product;
   logic        drain_cool, drain_cool_next;
   logic        drain_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          temp_q <= HEAT_OFF_B;
      else if (temp_valid) temp_q <= temp;
   end

   // Difference is clamped at zero so the cycle before leaving a mode never sees a wrapped value.
   always_comb begin
      diff = 8'd0;
      case (state)
         S_COOL:  if (temp_q > COOL_OFF_B) diff = temp_q - COOL_OFF_B;
         S_HEAT:  if (temp_q < HEAT_OFF_B) diff = HEAT_OFF_B - temp_q;
         default: diff = 8'd0;
      endcase
      product = {8'd0, diff} * GAIN_W;
      target  = (product > 16'd255) ? 8'hFF : product[7:0];
   end

`ifdef SOFT_START_EN
   assign drain_done = (speed == 8'd0);
`else
   assign drain_done = 1'b1;
`endif

   always_comb begin
      next_state      = state;
      drain_cool_next = drain_cool;
      case (state)
         S_IDLE: begin
            if (enable && temp_q >= COOL_ON_B)      next_state = S_COOL;
            else if (enable && temp_q <= HEAT_ON_B) next_state = S_HEAT;
         end
         S_COOL: begin
            if (!enable || temp_q <= COOL_OFF_B) begin
               next_state      = S_DRAIN;
               drain_cool_next = 1'b1;
            end
         end
         S_HEAT: begin
            if (!enable || temp_q >= HEAT_OFF_B) begin
               next_state      = S_DRAIN;
               drain_cool_next = 1'b0;
            end
         end
         default: begin
            if (drain_done) next_state = S_IDLE;
         end
      endcase
   end

`ifdef SOFT_START_EN
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [8:0]    STEP_W    = 9'(STEP);

   logic [CW-1:0] tick_cnt;
   logic [8:0]    speed_up, down_floor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + CW'(1);
   end

   // 9-bit sums keep the step from wrapping past 0 or 255.
   always_comb begin
      speed_up   = {1'b0, speed} + STEP_W;
      down_floor = {1'b0, target} + STEP_W;
      speed_next = speed;
      if (tick_cnt == TICK_LAST) begin
         if (speed < target)
            speed_next = (speed_up > {1'b0, target}) ? target : speed_up[7:0];
         else if (speed > target)
            speed_next = ({1'b0, speed} < down_floor) ? target : speed - STEP_W[7:0];
      end
   end
`else
   always_comb begin
      speed_next = (next_state == S_DRAIN) ? 8'd0 : target;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         speed      <= 8'd0;
         cool_en    <= 1'b0;
         heat_en    <= 1'b0;
         busy       <= 1'b0;
         drain_cool <= 1'b0;
      end else begin
         state      <= next_state;
         speed      <= speed_next;
         drain_cool <= drain_cool_next;
         cool_en    <= (next_state == S_COOL) || ((next_state == S_DRAIN) && drain_cool_next);
         heat_en    <= (next_state == S_HEAT) || ((next_state == S_DRAIN) && !drain_cool_next);
         busy       <= (next_state != S_IDLE);
      end
   end

endmodule

// File: tb/tb_cool_heat_ctrl.sv
// Bench for cool_heat_ctrl: cycle model feeds an expected queue, DUT outputs compared every cycle.
// Follows SOFT_START_EN the same way the design does.
module tb_cool_heat_ctrl;

   localparam int HEAT_ON  = 15;
   localparam int HEAT_OFF = 20;
   localparam int COOL_OFF = 30;
   localparam int COOL_ON  = 35;
   localparam int GAIN     = 16;
   localparam int TICK_DIV = 16;
   localparam int STEP     = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] temp = 8'd0;
   logic       temp_valid = 1'b0;
   logic [7:0] speed;
   logic       cool_en, heat_en, busy;

   int n_tests = 0;
   int n_fail  = 0;

   // expected word: {busy, cool_en, heat_en, speed}
   logic [10:0] exp_q[$];

   // model state: 0 idle, 1 cool, 2 heat, 3 drain
   int m_state, m_speed, m_cnt, m_tq;
   bit m_dc;

   cool_heat_ctrl #(
      .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF), .COOL_OFF(COOL_OFF), .COOL_ON(COOL_ON),
      .GAIN(GAIN), .TICK_DIV(TICK_DIV), .STEP(STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .temp(temp), .temp_valid(temp_valid),
      .speed(speed), .cool_en(cool_en), .heat_en(heat_en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_speed = 0;
      m_cnt   = 0;
      m_tq    = HEAT_OFF;
      m_dc    = 1'b0;
      exp_q.delete();
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      int tgt, ns;
      bit dcn;
      logic [7:0] sp8;
      tgt = 0;
      if (m_state == 1 && m_tq > COOL_OFF) tgt = (m_tq - COOL_OFF) * GAIN;
      if (m_state == 2 && m_tq < HEAT_OFF) tgt = (HEAT_OFF - m_tq) * GAIN;
      if (tgt > 255) tgt = 255;
      ns  = m_state;
      dcn = m_dc;
      case (m_state)
         0: begin
            if (enable && m_tq >= COOL_ON)      ns = 1;
            else if (enable && m_tq <= HEAT_ON) ns = 2;
         end
         1: if (!enable || m_tq <= COOL_OFF) begin ns = 3; dcn = 1'b1; end
         2: if (!enable || m_tq >= HEAT_OFF) begin ns = 3; dcn = 1'b0; end
         default: begin
`ifdef SOFT_START_EN
            if (m_speed == 0) ns = 0;
`else
            ns = 0;
`endif
         end
      endcase
`ifdef SOFT_START_EN
      if (m_cnt == TICK_DIV - 1) begin
         if (m_speed < tgt)      m_speed = (m_speed + STEP > tgt) ? tgt : m_speed + STEP;
         else if (m_speed > tgt) m_speed = (m_speed - STEP < tgt) ? tgt : m_speed - STEP;
      end
      m_cnt = (m_cnt + 1) % TICK_DIV;
`else
      m_speed = (ns == 3) ? 0 : tgt;
`endif
      if (temp_valid) m_tq = int'(temp);
      m_state = ns;
      m_dc    = dcn;
      sp8 = m_speed[7:0];
      exp_q.push_back({ns != 0, (ns == 1) || (ns == 3 && dcn), (ns == 2) || (ns == 3 && !dcn), sp8});
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle();
      logic [10:0] exp;
      model_edge();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_underrun", 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check("cycle", {21'd0, busy, cool_en, heat_en, speed}, {21'd0, exp});
      end
      temp_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic strobe(input int t);
      temp       = 8'(t);
      temp_valid = 1'b1;
      cycle();
   endtask

   initial begin
      int k;
      model_reset();
      #12;
      check("rst_speed", {24'd0, speed}, 32'd0);
      check("rst_cool", {31'd0, cool_en}, 32'd0);
      check("rst_heat", {31'd0, heat_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // mid-band temperature keeps the controller idle
      enable = 1'b1;
      strobe(25);
      run(999);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_speed", {24'd0, speed}, 32'd0);

      // cooling ramp to (40-30)*16 = 160
      strobe(40);
      run(700);
      check("cool_speed_160", {24'd0, speed}, 32'd160);
      check("cool_en_on", {31'd0, cool_en}, 32'd1);
      check("cool_heat_off", {31'd0, heat_en}, 32'd0);

      // saturated target
      strobe(50);
      run(450);
      check("cool_speed_sat", {24'd0, speed}, 32'd255);

      strobe(40);
      run(450);
      check("cool_back_160", {24'd0, speed}, 32'd160);

      // exit COOL: drain to zero then idle
      strobe(28);
      run(800);
      check("drain_speed0", {24'd0, speed}, 32'd0);
      check("drain_cool_off", {31'd0, cool_en}, 32'd0);
      check("drain_idle", {31'd0, busy}, 32'd0);

      // heating, then enable drop mid-ramp
      strobe(10);
      run(300);
      check("heat_en_on", {31'd0, heat_en}, 32'd1);
      enable = 1'b0;
      run(700);
      check("heat_drained", {31'd0, heat_en}, 32'd0);
      check("heat_idle", {31'd0, busy}, 32'd0);

      // HEAT to COOL must pass through DRAIN and IDLE
      enable = 1'b1;
      run(200);
      strobe(40);
      run(1500);
      check("swap_cool_en", {31'd0, cool_en}, 32'd1);
      check("swap_speed", {24'd0, speed}, 32'd160);

      // random strobes and enable toggles around the thresholds
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            temp       = 8'($urandom_range(0, 60));
            temp_valid = 1'b1;
         end
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         cycle();
      end

      // asynchronous reset in the middle of a ramp
      enable = 1'b0;
      run(1200);
      enable = 1'b1;
      strobe(40);
      k = 0;
      while (m_speed < 100 && k < 2000) begin
         cycle();
         k++;
      end
      check("ramp_reached", {31'd0, speed >= 8'd100}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_speed", {24'd0, speed}, 32'd0);
      check("async_cool", {31'd0, cool_en}, 32'd0);
      check("async_heat", {31'd0, heat_en}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      run(20);
      check("post_rst_idle", {31'd0, busy}, 32'd0);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
